// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, load/store and memory-port signal bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int MADDR_WIDTH = 32
);
  // fetch requester
  logic                      if_req_valid;
  logic                      if_req_ready;
  logic [MADDR_WIDTH-1:0]    if_req_addr;
  logic                      if_resp_valid;
  logic [DATA_WIDTH-1:0]     if_resp_data;

  // load/store requester
  logic                      ls_req_valid;
  logic                      ls_req_ready;
  logic [MADDR_WIDTH-1:0]    ls_req_addr;
  logic                      ls_req_wen;
  logic [DATA_WIDTH/8-1:0]   ls_req_wmask;
  logic [DATA_WIDTH-1:0]     ls_req_wdata;
  logic                      ls_resp_valid;
  logic [DATA_WIDTH-1:0]     ls_resp_data;

  // shared downstream memory port
  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic [MADDR_WIDTH-1:0]    mem_req_addr;
  logic                      mem_req_wen;
  logic [DATA_WIDTH/8-1:0]   mem_req_wmask;
  logic [DATA_WIDTH-1:0]     mem_req_wdata;
  logic                      mem_resp_valid;
  logic [DATA_WIDTH-1:0]     mem_resp_data;

  // arbiter view
  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_resp_valid, if_resp_data,
    input  ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wmask, ls_req_wdata,
    output ls_req_ready, ls_resp_valid, ls_resp_data,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask, mem_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  // requester/memory environment view
  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_resp_valid, if_resp_data,
    output ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wmask, ls_req_wdata,
    input  ls_req_ready, ls_resp_valid, ls_resp_data,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin two-requester arbiter onto one memory port, single outstanding transaction
module mem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int MADDR_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic          busy
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic SRC_IF = 1'b0;
  localparam logic SRC_LS = 1'b1;

  logic [1:0]             state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   last_grant_q, last_grant_d;
  logic [MADDR_WIDTH-1:0] addr_q, addr_d;
  logic                   wen_q, wen_d;
  logic [MASK_WIDTH-1:0]  wmask_q, wmask_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic                   if_resp_valid_q, if_resp_valid_d;
  logic                   ls_resp_valid_q, ls_resp_valid_d;
  logic [DATA_WIDTH-1:0]  if_resp_data_q, if_resp_data_d;
  logic [DATA_WIDTH-1:0]  ls_resp_data_q, ls_resp_data_d;

  logic is_idle;
  logic sel_ls;
  logic if_hs;
  logic ls_hs;

  // Pick the winner in IDLE: a lone requester wins, a tie goes to whoever was not granted last.
  // Readies are also held low while reset is asserted so nothing is accepted during reset.
  always_comb begin
    is_idle = (state_q == ST_IDLE);
    sel_ls  = 1'b0;
    if (bus.ls_req_valid && !bus.if_req_valid) begin
      sel_ls = 1'b1;
    end else if (bus.ls_req_valid && bus.if_req_valid) begin
      sel_ls = (last_grant_q == SRC_IF);
    end
    if_hs = rst && is_idle && bus.if_req_valid && !sel_ls;
    ls_hs = rst && is_idle && bus.ls_req_valid && sel_ls;
  end

  assign bus.if_req_ready  = if_hs;
  assign bus.ls_req_ready  = ls_hs;

  assign bus.mem_req_valid = (state_q == ST_REQ);
  assign bus.mem_req_addr  = addr_q;
  assign bus.mem_req_wen   = wen_q;
  assign bus.mem_req_wmask = wmask_q;
  assign bus.mem_req_wdata = wdata_q;

  assign bus.if_resp_valid = if_resp_valid_q;
  assign bus.if_resp_data  = if_resp_data_q;
  assign bus.ls_resp_valid = ls_resp_valid_q;
  assign bus.ls_resp_data  = ls_resp_data_q;

  assign busy = (state_q != ST_IDLE);

  // Next-state: latch the accepted request, wait for the downstream handshake, then route the response.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_grant_d    = last_grant_q;
    addr_d          = addr_q;
    wen_d           = wen_q;
    wmask_d         = wmask_q;
    wdata_d         = wdata_q;
    if_resp_valid_d = 1'b0;
    ls_resp_valid_d = 1'b0;
    if_resp_data_d  = if_resp_data_q;
    ls_resp_data_d  = ls_resp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (if_hs) begin
          // Fetch is read-only, so the write fields are forced to zero on the memory port.
          addr_d       = bus.if_req_addr;
          wen_d        = 1'b0;
          wmask_d      = '0;
          wdata_d      = '0;
          owner_d      = SRC_IF;
          last_grant_d = SRC_IF;
          state_d      = ST_REQ;
        end else if (ls_hs) begin
          addr_d       = bus.ls_req_addr;
          wen_d        = bus.ls_req_wen;
          wmask_d      = bus.ls_req_wmask;
          wdata_d      = bus.ls_req_wdata;
          owner_d      = SRC_LS;
          last_grant_d = SRC_LS;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        // A response arriving alongside the request handshake is not ours yet and is ignored.
        if (bus.mem_req_ready) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.mem_resp_valid) begin
          if (owner_q == SRC_LS) begin
            ls_resp_data_d  = bus.mem_resp_data;
            ls_resp_valid_d = 1'b1;
          end else begin
            if_resp_data_d  = bus.mem_resp_data;
            if_resp_valid_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight transaction without a response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      owner_q         <= SRC_IF;
      last_grant_q    <= SRC_IF;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      wmask_q         <= '0;
      wdata_q         <= '0;
      if_resp_valid_q <= 1'b0;
      ls_resp_valid_q <= 1'b0;
      if_resp_data_q  <= '0;
      ls_resp_data_q  <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      last_grant_q    <= last_grant_d;
      addr_q          <= addr_d;
      wen_q           <= wen_d;
      wmask_q         <= wmask_d;
      wdata_q         <= wdata_d;
      if_resp_valid_q <= if_resp_valid_d;
      ls_resp_valid_q <= ls_resp_valid_d;
      if_resp_data_q  <= if_resp_data_d;
      ls_resp_data_q  <= ls_resp_data_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  mem_arbiter_if #(.DATA_WIDTH(DW), .MADDR_WIDTH(AW)) bus ();

  mem_arbiter #(.DATA_WIDTH(DW), .MADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: who was granted last, and what each response port should be holding
  bit            last_ls;
  logic [DW-1:0] exp_if_data;
  logic [DW-1:0] exp_ls_data;
  bit            grants[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_if(input logic [AW-1:0] a);
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = a;
  endtask

  task automatic set_ls(input logic [AW-1:0] a, input logic w, input logic [MW-1:0] m, input logic [DW-1:0] d);
    bus.ls_req_valid = 1'b1;
    bus.ls_req_addr  = a;
    bus.ls_req_wen   = w;
    bus.ls_req_wmask = m;
    bus.ls_req_wdata = d;
  endtask

  task automatic check_no_pulse(input string tag);
    check({tag, "_if_resp_valid"}, bus.if_resp_valid, 1'b0);
    check({tag, "_ls_resp_valid"}, bus.ls_resp_valid, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check("rst_if_req_ready", bus.if_req_ready, 1'b0);
    check("rst_ls_req_ready", bus.ls_req_ready, 1'b0);
    check("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
    check("rst_mem_req_addr", bus.mem_req_addr, '0);
    check("rst_mem_req_wen", bus.mem_req_wen, 1'b0);
    check("rst_mem_req_wmask", bus.mem_req_wmask, '0);
    check("rst_mem_req_wdata", bus.mem_req_wdata, '0);
    check("rst_if_resp_valid", bus.if_resp_valid, 1'b0);
    check("rst_if_resp_data", bus.if_resp_data, '0);
    check("rst_ls_resp_valid", bus.ls_resp_valid, 1'b0);
    check("rst_ls_resp_data", bus.ls_resp_data, '0);
    check("rst_busy", busy, 1'b0);
  endtask

  task automatic model_reset();
    last_ls     = 1'b0;
    exp_if_data = '0;
    exp_ls_data = '0;
  endtask

  // One full transaction, entered at a negedge with requests already driven.
  task automatic txn(input int req_stall, input int resp_stall, input bit stray,
                     input bit abort, input bit use_fixed, input logic [DW-1:0] fixed_data);
    bit            win_ls;
    logic [AW-1:0] e_addr;
    logic          e_wen;
    logic [MW-1:0] e_mask;
    logic [DW-1:0] e_wdata;
    logic [DW-1:0] rdata;
    #1;
    if (bus.if_req_valid && bus.ls_req_valid) win_ls = !last_ls;
    else win_ls = bus.ls_req_valid;
    check("idle_busy", busy, 1'b0);
    check("if_req_ready", bus.if_req_ready, bus.if_req_valid && !win_ls);
    check("ls_req_ready", bus.ls_req_ready, bus.ls_req_valid && win_ls);
    if (win_ls) begin
      e_addr = bus.ls_req_addr; e_wen = bus.ls_req_wen; e_mask = bus.ls_req_wmask; e_wdata = bus.ls_req_wdata;
    end else begin
      e_addr = bus.if_req_addr; e_wen = 1'b0; e_mask = '0; e_wdata = '0;
    end
    @(posedge clk);
    last_ls = win_ls;
    grants.push_back(win_ls);
    @(negedge clk);
    // the accepted requester withdraws and scribbles over its inputs
    if (win_ls) begin
      bus.ls_req_valid = 1'b0; bus.ls_req_addr = $urandom; bus.ls_req_wen = $urandom;
      bus.ls_req_wmask = $urandom; bus.ls_req_wdata = $urandom;
    end else begin
      bus.if_req_valid = 1'b0; bus.if_req_addr = $urandom;
    end
    for (int i = 0; i <= req_stall; i++) begin
      if (i > 0) @(negedge clk);
      bus.mem_req_ready  = (i == req_stall);
      bus.mem_resp_valid = stray;
      bus.mem_resp_data  = $urandom;
      #1;
      check("req_mem_req_valid", bus.mem_req_valid, 1'b1);
      check("req_mem_req_addr", bus.mem_req_addr, e_addr);
      check("req_mem_req_wen", bus.mem_req_wen, e_wen);
      check("req_mem_req_wmask", bus.mem_req_wmask, e_mask);
      check("req_mem_req_wdata", bus.mem_req_wdata, e_wdata);
      check("req_busy", busy, 1'b1);
      check("req_if_req_ready", bus.if_req_ready, 1'b0);
      check("req_ls_req_ready", bus.ls_req_ready, 1'b0);
      check_no_pulse("req");
    end
    @(negedge clk);
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    #1;
    check("resp_mem_req_valid", bus.mem_req_valid, 1'b0);
    check("resp_busy", busy, 1'b1);
    check_no_pulse("resp");
    if (abort) begin
      bus.if_req_valid = 1'b0;
      bus.ls_req_valid = 1'b0;
      rst = 1'b0;
      #1;
      model_reset();
      check_reset_outputs();
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = $urandom;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_no_pulse("abort_release");
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      #1;
      check_no_pulse("abort_after");
      check("abort_busy", busy, 1'b0);
      return;
    end
    rdata = '0;
    for (int i = 0; i <= resp_stall; i++) begin
      if (i > 0) @(negedge clk);
      rdata = use_fixed ? fixed_data : DW'($urandom);
      bus.mem_resp_valid = (i == resp_stall);
      bus.mem_resp_data  = rdata;
      #1;
      check("resp_wait_busy", busy, 1'b1);
      check_no_pulse("resp_wait");
    end
    if (win_ls) exp_ls_data = rdata;
    else exp_if_data = rdata;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = $urandom;
    #1;
    check("pulse_if_resp_valid", bus.if_resp_valid, !win_ls);
    check("pulse_ls_resp_valid", bus.ls_resp_valid, win_ls);
    check("pulse_if_resp_data", bus.if_resp_data, exp_if_data);
    check("pulse_ls_resp_data", bus.ls_resp_data, exp_ls_data);
    check("pulse_busy", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ls_first;
    bus.if_req_valid = 1'b0; bus.if_req_addr = '0;
    bus.ls_req_valid = 1'b0; bus.ls_req_addr = '0; bus.ls_req_wen = 1'b0;
    bus.ls_req_wmask = '0;   bus.ls_req_wdata = '0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
    model_reset();
    rst = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // contention right after reset: expect LS, IF, LS, IF
    set_if($urandom);
    set_ls($urandom, $urandom, $urandom, $urandom);
    for (int k = 0; k < 4; k++) begin
      txn($urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 1'b0, 1'b0, '0);
      if (!bus.if_req_valid) set_if($urandom);
      if (!bus.ls_req_valid) set_ls($urandom, $urandom, $urandom, $urandom);
    end
    bus.if_req_valid = 1'b0;
    bus.ls_req_valid = 1'b0;

    // single fetch at minimum latency
    set_if(32'h8000_0000);
    txn(0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0413);

    // store held through three downstream stall cycles
    set_ls(32'h8000_1004, 1'b1, 4'b0011, 32'hDEAD_BEEF);
    txn(3, 1, 1'b0, 1'b0, 1'b0, '0);

    // stray responses while idle
    @(negedge clk);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = $urandom;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("stray_idle_busy", busy, 1'b0);
      check("stray_idle_mem_req_valid", bus.mem_req_valid, 1'b0);
      check_no_pulse("stray_idle");
      check("stray_idle_if_data", bus.if_resp_data, exp_if_data);
      check("stray_idle_ls_data", bus.ls_resp_data, exp_ls_data);
    end
    bus.mem_resp_valid = 1'b0;

    // stray responses during REQ, including the downstream handshake cycle
    set_if($urandom);
    txn(2, 0, 1'b1, 1'b0, 1'b0, '0);

    // randomized traffic; a losing requester keeps its request pending
    for (int k = 0; k < 40; k++) begin
      if (!bus.if_req_valid && ($urandom_range(0, 1) == 1)) set_if($urandom);
      if (!bus.ls_req_valid && ($urandom_range(0, 1) == 1)) set_ls($urandom, $urandom, $urandom, $urandom);
      if (!bus.if_req_valid && !bus.ls_req_valid) set_ls($urandom, $urandom, $urandom, $urandom);
      txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), 1'b0, 1'b0, '0);
    end
    bus.if_req_valid = 1'b0;
    bus.ls_req_valid = 1'b0;

    // reset while waiting for the response, then a tie must go to LS
    set_if($urandom);
    txn(1, 0, 1'b0, 1'b1, 1'b0, '0);
    set_if($urandom);
    set_ls($urandom, $urandom, $urandom, $urandom);
    txn(0, 0, 1'b0, 1'b0, 1'b0, '0);
    ls_first = grants[grants.size() - 1];
    check("tie_after_reset_goes_ls", ls_first, 1'b1);
    bus.if_req_valid = 1'b0;
    bus.ls_req_valid = 1'b0;

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
